// File: rtl/hadamard_stream_ctrl_if.sv
// Stream/lane-bus bundle between the sample stream, the controller and
// complexhadamard. The controller takes the master view; the environment
// (sample source, hadamard core, sink) takes the slave view.
interface hadamard_stream_ctrl_if #(
  parameter int formatWidth = 9
);
  logic                     s_valid;
  logic                     s_ready;
  logic [formatWidth-1:0]   s_real;
  logic [formatWidth-1:0]   s_imag;
  logic [formatWidth-1:0]   s_tw_real;
  logic [formatWidth-1:0]   s_tw_imag;

  logic                     hd_start;
  logic [4*formatWidth-1:0] hd_input_real;
  logic [4*formatWidth-1:0] hd_input_imag;
  logic [4*formatWidth-1:0] hd_twiddle_real;
  logic [4*formatWidth-1:0] hd_twiddle_imag;
  logic [4*formatWidth-1:0] hd_output_real;
  logic [4*formatWidth-1:0] hd_output_imag;
  logic                     hd_done;

  logic                     m_valid;
  logic                     m_ready;
  logic [formatWidth-1:0]   m_real;
  logic [formatWidth-1:0]   m_imag;
  logic                     m_last;

  modport master (
    input  s_valid, s_real, s_imag, s_tw_real, s_tw_imag,
    output s_ready,
    output hd_start, hd_input_real, hd_input_imag, hd_twiddle_real, hd_twiddle_imag,
    input  hd_output_real, hd_output_imag, hd_done,
    output m_valid, m_real, m_imag, m_last,
    input  m_ready
  );

  modport slave (
    output s_valid, s_real, s_imag, s_tw_real, s_tw_imag,
    input  s_ready,
    input  hd_start, hd_input_real, hd_input_imag, hd_twiddle_real, hd_twiddle_imag,
    output hd_output_real, hd_output_imag, hd_done,
    input  m_valid, m_real, m_imag, m_last,
    output m_ready
  );
endinterface

// File: rtl/hadamard_stream_ctrl.sv
// Streaming wrapper around complexhadamard: gathers four samples (with their
// twiddles) into the lane buses, fires the core, waits for done with a
// timeout, captures the four results and replays them as a serial stream.
// Only one frame is ever in flight, so input and output never overlap.
module hadamard_stream_ctrl #(
  parameter int formatWidth = 9,
  parameter int TIMEOUT     = 16,
  parameter int CNTW        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  hadamard_stream_ctrl_if.master bus,
  output logic                   timeout_err,
  output logic [CNTW-1:0]        frame_cnt
);

  localparam int             WCW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_FIRE    = 2'd1,
    S_WAIT    = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       lane;
  logic [WCW-1:0]   wcnt;
  logic             in_ready;
  logic             start_pulse;
  logic             out_valid;
  logic             accept;
  logic             advance;

  logic [formatWidth-1:0] in_re  [4];
  logic [formatWidth-1:0] in_im  [4];
  logic [formatWidth-1:0] tw_re  [4];
  logic [formatWidth-1:0] tw_im  [4];
  logic [formatWidth-1:0] cap_re [4];
  logic [formatWidth-1:0] cap_im [4];

  assign accept  = bus.s_valid && in_ready;
  assign advance = out_valid && bus.m_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_COLLECT;
    else      state <= state_nxt;
  end

  // Next-state and state-decoded handshake outputs (no path from s_valid/m_ready to s_ready)
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    start_pulse = 1'b0;
    out_valid   = 1'b0;
    case (state)
      S_COLLECT: begin
        in_ready = 1'b1;
        if (bus.s_valid && lane == 2'd3) state_nxt = S_FIRE;
      end
      S_FIRE: begin
        start_pulse = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        // done has priority over an expiring counter in the same cycle
        if (bus.hd_done)             state_nxt = S_DRAIN;
        else if (wcnt == WAIT_LAST)  state_nxt = S_COLLECT;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (bus.m_ready && lane == 2'd3) state_nxt = S_COLLECT;
      end
      default: state_nxt = S_COLLECT;
    endcase
  end

  // Lane/wait counters, lane buses, result capture and status
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane        <= 2'd0;
      wcnt        <= '0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
      for (int k = 0; k < 4; k++) begin
        in_re[k]  <= '0;
        in_im[k]  <= '0;
        tw_re[k]  <= '0;
        tw_im[k]  <= '0;
        cap_re[k] <= '0;
        cap_im[k] <= '0;
      end
    end else begin
      case (state)
        S_COLLECT: begin
          if (accept) begin
            in_re[lane] <= bus.s_real;
            in_im[lane] <= bus.s_imag;
            tw_re[lane] <= bus.s_tw_real;
            tw_im[lane] <= bus.s_tw_imag;
            lane        <= lane + 2'd1;
          end
        end
        S_FIRE: wcnt <= '0;
        S_WAIT: begin
          if (bus.hd_done) begin
            for (int k = 0; k < 4; k++) begin
              cap_re[k] <= bus.hd_output_real[k*formatWidth +: formatWidth];
              cap_im[k] <= bus.hd_output_imag[k*formatWidth +: formatWidth];
            end
          end else if (wcnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        S_DRAIN: begin
          if (advance) begin
            lane <= lane + 2'd1;
            if (lane == 2'd3) frame_cnt <= frame_cnt + CNTW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign bus.hd_input_real  [k*formatWidth +: formatWidth] = in_re[k];
    assign bus.hd_input_imag  [k*formatWidth +: formatWidth] = in_im[k];
    assign bus.hd_twiddle_real[k*formatWidth +: formatWidth] = tw_re[k];
    assign bus.hd_twiddle_imag[k*formatWidth +: formatWidth] = tw_im[k];
  end

  assign bus.s_ready  = in_ready;
  assign bus.hd_start = start_pulse;
  assign bus.m_valid  = out_valid;
  assign bus.m_real   = out_valid ? cap_re[lane] : '0;
  assign bus.m_imag   = out_valid ? cap_im[lane] : '0;
  assign bus.m_last   = out_valid && (lane == 2'd3);

endmodule

// File: tb/tb_hadamard_stream_ctrl.sv
// Directed bench for hadamard_stream_ctrl: frames with nominal done, output
// back-pressure, timeout, mid-frame reset, done on the expiry cycle and a
// spurious done outside the wait window.
module tb_hadamard_stream_ctrl;
  localparam int FW      = 9;
  localparam int TIMEOUT = 16;
  localparam int CNTW    = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            timeout_err;
  logic [CNTW-1:0] frame_cnt;
  int              n_checks = 0;
  int              n_fail   = 0;

  hadamard_stream_ctrl_if #(.formatWidth(FW)) bus ();

  hadamard_stream_ctrl #(
    .formatWidth(FW),
    .TIMEOUT    (TIMEOUT),
    .CNTW       (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .timeout_err(timeout_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*FW-1:0] pack4(input logic [FW-1:0] base);
    return {base + 9'd3, base + 9'd2, base + 9'd1, base};
  endfunction

  // Four back-to-back samples; returns sitting in the FIRE cycle.
  task automatic send4(input logic [FW-1:0] re, input logic [FW-1:0] im,
                       input logic [FW-1:0] twr, input logic [FW-1:0] twi);
    for (int i = 0; i < 4; i++) begin
      bus.s_valid   = 1'b1;
      bus.s_real    = re  + FW'(i);
      bus.s_imag    = im  + FW'(i);
      bus.s_tw_real = twr;
      bus.s_tw_imag = twi + FW'(i);
      check_val("s_ready_collect", bus.s_ready, 1);
      tick();
    end
    bus.s_valid = 1'b0;
    check_val("hd_start_fire", bus.hd_start, 1);
    check_val("s_ready_fire", bus.s_ready, 0);
    check_val("hd_in_re", bus.hd_input_real, pack4(re));
    check_val("hd_in_im", bus.hd_input_imag, pack4(im));
    check_val("hd_tw_re", bus.hd_twiddle_real, {4{twr}});
    check_val("hd_tw_im", bus.hd_twiddle_imag, pack4(twi));
  endtask

  // From the FIRE cycle F, raise hd_done in cycle F+done_at; ends in DRAIN.
  task automatic respond(input int done_at, input logic [FW-1:0] in_re,
                         input logic [FW-1:0] out_re, input logic [FW-1:0] out_im);
    tick();
    check_val("hd_start_pulse", bus.hd_start, 0);
    repeat (done_at - 1) tick();
    check_val("hd_in_stable", bus.hd_input_real, pack4(in_re));
    check_val("m_valid_wait", bus.m_valid, 0);
    check_val("s_ready_wait", bus.s_ready, 0);
    bus.hd_done        = 1'b1;
    bus.hd_output_real = pack4(out_re);
    bus.hd_output_imag = pack4(out_im);
    tick();
    bus.hd_done        = 1'b0;
    bus.hd_output_real = '1;
    bus.hd_output_imag = '1;
    check_val("m_valid_drain", bus.m_valid, 1);
  endtask

  // Drain the four captured lanes; stall_lane (0..3) holds m_ready low 3 cycles.
  task automatic drain(input logic [FW-1:0] re, input logic [FW-1:0] im, input int stall_lane);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_lane) begin
        bus.m_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          check_val("m_valid_stall", bus.m_valid, 1);
          check_val("m_real_stall", bus.m_real, re + FW'(k));
          check_val("m_last_stall", bus.m_last, (k == 3));
          tick();
        end
        bus.m_ready = 1'b1;
      end
      check_val("m_valid", bus.m_valid, 1);
      check_val("m_real", bus.m_real, re + FW'(k));
      check_val("m_imag", bus.m_imag, im + FW'(k));
      check_val("m_last", bus.m_last, (k == 3));
      check_val("s_ready_drain", bus.s_ready, 0);
      tick();
    end
    check_val("m_valid_after", bus.m_valid, 0);
    check_val("s_ready_after", bus.s_ready, 1);
  endtask

  initial begin
    bus.s_valid        = 1'b0;
    bus.s_real         = '0;
    bus.s_imag         = '0;
    bus.s_tw_real      = '0;
    bus.s_tw_imag      = '0;
    bus.hd_done        = 1'b0;
    bus.hd_output_real = '0;
    bus.hd_output_imag = '0;
    bus.m_ready        = 1'b1;

    // Reset state
    rst = 1'b0;
    repeat (2) tick();
    check_val("rst_s_ready", bus.s_ready, 1);
    check_val("rst_m_valid", bus.m_valid, 0);
    check_val("rst_hd_start", bus.hd_start, 0);
    check_val("rst_hd_in_re", bus.hd_input_real, 0);
    check_val("rst_err", timeout_err, 0);
    check_val("rst_cnt", frame_cnt, 0);
    rst = 1'b1;
    tick();

    // Nominal frame
    send4(9'h011, 9'h021, 9'h080, 9'h000);
    respond(4, 9'h011, 9'h0A0, 9'h050);
    check_val("cnt_before", frame_cnt, 0);
    drain(9'h0A0, 9'h050, -1);
    check_val("cnt_frame1", frame_cnt, 1);

    // Back-pressure on lane 1
    send4(9'h041, 9'h061, 9'h100, 9'h033);
    respond(4, 9'h041, 9'h1C0, 9'h1E0);
    drain(9'h1C0, 9'h1E0, 1);
    check_val("cnt_frame2", frame_cnt, 2);

    // Timeout: no done for TIMEOUT cycles in WAIT
    send4(9'h005, 9'h015, 9'h0FF, 9'h010);
    tick();
    check_val("to_start_pulse", bus.hd_start, 0);
    repeat (TIMEOUT - 1) tick();
    check_val("to_err_pending", timeout_err, 0);
    check_val("to_s_ready_wait", bus.s_ready, 0);
    tick();
    check_val("to_err_set", timeout_err, 1);
    check_val("to_s_ready", bus.s_ready, 1);
    check_val("to_m_valid", bus.m_valid, 0);
    check_val("to_cnt", frame_cnt, 2);
    send4(9'h0F1, 9'h0E1, 9'h080, 9'h001);
    respond(4, 9'h0F1, 9'h123, 9'h045);
    drain(9'h123, 9'h045, 3);
    check_val("cnt_frame3", frame_cnt, 3);
    check_val("err_sticky", timeout_err, 1);

    // Reset with a partial frame collected
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1'b1;
      bus.s_real  = 9'h1F0 + FW'(i);
      bus.s_imag  = 9'h1E0 + FW'(i);
      tick();
    end
    bus.s_valid = 1'b0;
    rst = 1'b0;
    tick();
    check_val("rst2_s_ready", bus.s_ready, 1);
    check_val("rst2_hd_in_re", bus.hd_input_real, 0);
    check_val("rst2_hd_in_im", bus.hd_input_imag, 0);
    check_val("rst2_err", timeout_err, 0);
    check_val("rst2_cnt", frame_cnt, 0);
    check_val("rst2_m_real", bus.m_real, 0);
    rst = 1'b1;
    send4(9'h031, 9'h071, 9'h080, 9'h002);
    respond(4, 9'h031, 9'h0B0, 9'h0C0);
    drain(9'h0B0, 9'h0C0, -1);
    check_val("cnt_after_rst", frame_cnt, 1);

    // Spurious done in COLLECT is ignored
    bus.hd_done        = 1'b1;
    bus.hd_output_real = pack4(9'h155);
    bus.hd_output_imag = pack4(9'h166);
    tick();
    bus.hd_done = 1'b0;
    check_val("spur_m_valid", bus.m_valid, 0);
    check_val("spur_s_ready", bus.s_ready, 1);
    tick();
    check_val("spur_m_valid2", bus.m_valid, 0);

    // Done on the exact expiry cycle wins
    send4(9'h0D1, 9'h0C1, 9'h080, 9'h003);
    respond(TIMEOUT, 9'h0D1, 9'h07A, 9'h08B);
    check_val("exp_err_clear", timeout_err, 0);
    drain(9'h07A, 9'h08B, 2);
    check_val("cnt_exp", frame_cnt, 2);
    check_val("exp_err_final", timeout_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
